// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-rate index names, the rate list and the divisor lookup.
package uart_pkg;

  typedef enum logic [3:0] {
    BAUD_9600    = 4'd0,
    BAUD_19200   = 4'd1,
    BAUD_38400   = 4'd2,
    BAUD_57600   = 4'd3,
    BAUD_115200  = 4'd4,
    BAUD_230400  = 4'd5,
    BAUD_460800  = 4'd6,
    BAUD_921600  = 4'd7,
    BAUD_1000000 = 4'd8,
    BAUD_1500000 = 4'd9
  } baud_sel_e;

  localparam int NUM_BAUDS = 10;

  localparam int unsigned BAUD_RATES [NUM_BAUDS] = '{
    9600, 19200, 38400, 57600, 115200,
    230400, 460800, 921600, 1000000, 1500000
  };

  // Unlisted indices fall back to the slowest rate.
  function automatic int unsigned baud_divisor(input int unsigned fpga_clk,
                                               input logic [3:0]  idx);
    int unsigned rate;
    rate = BAUD_RATES[0];
    for (int i = 1; i < NUM_BAUDS; i++) begin
      if (idx == 4'(i)) rate = BAUD_RATES[i];
    end
    return fpga_clk / rate;
  endfunction

endpackage

// File: rtl/baud_generator.sv
// Baud clock generator: one wrapping counter of N cycles plus registered decode of
// the square-wave clock and its rising / mid-high / falling strobes.
module baud_generator
  import uart_pkg::*;
#(
  parameter int unsigned FPGA_CLK = 100_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_baud_select,
  input  logic       i_update_baud,
  output logic       o_clk,
  output logic       o_rising_edge,
  output logic       o_falling_edge,
  output logic       o_stable
);

  localparam int CW = $clog2(FPGA_CLK / 9600 + 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DIV_RST = CW'(baud_divisor(FPGA_CLK, BAUD_9600));

  // Divisors are elaboration-time constants, so no runtime divider is built.
  logic [CW-1:0] div_tbl [16];
  for (genvar g = 0; g < 16; g++) begin : g_div_tbl
    assign div_tbl[g] = CW'(baud_divisor(FPGA_CLK, 4'(g)));
  end

  logic          en_q, en_d;
  logic [CW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_q, clk_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          stab_q, stab_d;
  logic [CW-1:0] sel_div;
  logic [CW-1:0] half_d;

  always_comb begin
    en_d    = en_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    sel_div = div_tbl[i_baud_select];

    // An update always restarts at the first low-phase count.
    if (i_update_baud) begin
      en_d  = 1'b1;
      div_d = sel_div;
      cnt_d = (sel_div >> 1) + ONE;
    end else if (en_q) begin
      cnt_d = (cnt_q == div_q - ONE) ? '0 : cnt_q + ONE;
    end

    // Outputs decode the next count so the registered outputs line up with cnt_q.
    half_d = div_d >> 1;
    clk_d  = en_d && (cnt_d <= half_d);
    rise_d = en_d && (cnt_d == div_d - ONE);
    fall_d = en_d && (cnt_d == half_d);
    stab_d = en_d && (cnt_d == (div_d >> 2));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q   <= 1'b0;
      div_q  <= DIV_RST;
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      stab_q <= 1'b0;
    end else begin
      en_q   <= en_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      stab_q <= stab_d;
    end
  end

  assign o_clk          = clk_q;
  assign o_rising_edge  = rise_q;
  assign o_falling_edge = fall_q;
  assign o_stable       = stab_q;

endmodule

// File: tb/tb_baud_generator.sv
// Directed bench for baud_generator: table of baud indices with hand-computed divisors.
module tb_baud_generator;

  logic       i_clk;
  logic       i_rst_n;
  logic [3:0] i_baud_select;
  logic       i_update_baud;
  logic       o_clk;
  logic       o_rising_edge;
  logic       o_falling_edge;
  logic       o_stable;

  int total = 0;
  int bad   = 0;

  baud_generator #(.FPGA_CLK(100_000_000)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_baud_select  (i_baud_select),
    .i_update_baud  (i_update_baud),
    .o_clk          (o_clk),
    .o_rising_edge  (o_rising_edge),
    .o_falling_edge (o_falling_edge),
    .o_stable       (o_stable)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] sel;
    int         n;       // expected divisor
    int         q;       // N/4: stable offset
    int         h;       // N/2: falling offset
    int         lat;     // cycles from update to first o_clk high
    int         cycles;  // cycles checked after the rise
  } vec_t;

  vec_t vecs [11];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] s, input int len);
    @(negedge i_clk);
    i_baud_select = s;
    i_update_baud = 1'b1;
    repeat (len) @(negedge i_clk);
    i_update_baud = 1'b0;
  endtask

  // Called at the first negedge after the last update edge.
  task automatic wait_rise(input int lat_exp, input string name);
    int lat;
    lat = 0;
    while (o_clk !== 1'b1 && lat < 20000) begin
      @(negedge i_clk);
      lat++;
    end
    cmp({name, " rise latency"}, lat, lat_exp);
  endtask

  task automatic check_period(input int n, input int q, input int h, input int cycles,
                              input string name);
    int m;
    int nr, ns, nf;
    logic [3:0] e, a;
    nr = 0; ns = 0; nf = 0;
    for (int k = 0; k < cycles; k++) begin
      m = k % n;
      e = {m <= h, m == q, m == h, m == n - 1};
      a = {o_clk, o_stable, o_falling_edge, o_rising_edge};
      total++;
      if (a !== e) begin
        bad++;
        if (bad < 20)
          $display("FAIL %s cyc%0d {clk,stb,fall,rise}: got %b want %b", name, k, a, e);
      end
      nr += int'(o_rising_edge === 1'b1);
      ns += int'(o_stable === 1'b1);
      nf += int'(o_falling_edge === 1'b1);
      @(negedge i_clk);
    end
    cmp({name, " rising count"},  nr, cycles / n);
    cmp({name, " stable count"},  ns, cycles / n);
    cmp({name, " falling count"}, nf, cycles / n);
  endtask

  task automatic check_idle(input int cycles, input string name);
    for (int k = 0; k < cycles; k++) begin
      cmp(name, {o_clk, o_stable, o_falling_edge, o_rising_edge}, 4'b0000);
      @(negedge i_clk);
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0,  10416, 2604, 5208, 5207, 10416};
    vecs[1]  = '{4'd1,   5208, 1302, 2604, 2603, 10416};
    vecs[2]  = '{4'd2,   2604,  651, 1302, 1301,  5208};
    vecs[3]  = '{4'd3,   1736,  434,  868,  867,  3472};
    vecs[4]  = '{4'd4,    868,  217,  434,  433,  1736};
    vecs[5]  = '{4'd5,    434,  108,  217,  216,   868};
    vecs[6]  = '{4'd6,    217,   54,  108,  108,   434};
    vecs[7]  = '{4'd7,    108,   27,   54,   53,   216};
    vecs[8]  = '{4'd8,    100,   25,   50,   49,   200};
    vecs[9]  = '{4'd9,     66,   16,   33,   32,   132};
    vecs[10] = '{4'd12, 10416, 2604, 5208, 5207, 10416};

    i_rst_n       = 1'b0;
    i_baud_select = 4'd0;
    i_update_baud = 1'b0;

    // Reset and idle
    repeat (16) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_idle(20, "idle after reset");

    // Table sweep
    for (int i = 0; i < 11; i++) begin
      string nm;
      nm = $sformatf("sel%0d", vecs[i].sel);
      pulse(vecs[i].sel, 1);
      cmp({nm, " low after update"}, o_clk, 1'b0);
      wait_rise(vecs[i].lat, nm);
      check_period(vecs[i].n, vecs[i].q, vecs[i].h, vecs[i].cycles, nm);
    end

    // Update held three cycles: restart on each, latency counts from the last
    pulse(4'd4, 3);
    cmp("held update low", o_clk, 1'b0);
    wait_rise(433, "held update");
    // Mid-high-phase switch to index 9
    repeat (100) @(negedge i_clk);
    cmp("mid period high", o_clk, 1'b1);
    pulse(4'd9, 1);
    cmp("switch low after update", o_clk, 1'b0);
    wait_rise(32, "switch");
    check_period(66, 16, 33, 66, "switch");

    // Async reset in the high phase, no clock edge between assert and check
    repeat (5) @(negedge i_clk);
    cmp("pre-reset high", o_clk, 1'b1);
    #2 i_rst_n = 1'b0;
    #1;
    cmp("async reset outputs", {o_clk, o_stable, o_falling_edge, o_rising_edge}, 4'b0000);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_idle(30, "idle after async reset");
    pulse(4'd9, 1);
    wait_rise(32, "post-reset");
    check_period(66, 16, 33, 66, "post-reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
